// File: rtl/chaos_lmap_gen_pkg.sv
// Shared constants, channel encoding and FSM states for the logistic-map source.
// Q0.32 samples, Q2.30 coefficient, five channels x1,x2,x3,z1,z2.
package chaos_lmap_gen_pkg;

  localparam int XW    = 32;
  localparam int PW    = 2 * XW;
  localparam int QR_LO = 30;
  localparam int NCH   = 5;

  localparam logic [XW-1:0] DEF_R_Q   = 32'hFD70_A3D7;
  localparam logic [XW-1:0] DEF_MIN_X = 32'h0001_0000;

  typedef enum logic [2:0] {
    CH_X1 = 3'd0,
    CH_X2 = 3'd1,
    CH_X3 = 3'd2,
    CH_Z1 = 3'd3,
    CH_Z2 = 3'd4
  } ch_e;

  localparam logic [2:0] LAST_CH = CH_Z2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DELIVER
  } state_e;

  // Pull a collapsing orbit off the 0 fixed point.
  function automatic logic [XW-1:0] floor_x(
    input logic [XW-1:0] y,
    input logic [XW-1:0] m
  );
    return (y < m) ? (y | m) : y;
  endfunction

endpackage

// File: rtl/chaos_lmap_gen_step.sv
// Two-phase shared multiply datapath: phase A t=hi(x*(1-x)), phase B y=r*t.
// Ports: clk, rst (sync, high), en, phase (0=A,1=B), x in; wb floored y out.
module lmap_step
  import chaos_lmap_gen_pkg::*;
#(
  parameter logic [XW-1:0] R_Q   = DEF_R_Q,
  parameter logic [XW-1:0] MIN_X = DEF_MIN_X
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          phase,
  input  logic [XW-1:0] x,
  output logic [XW-1:0] wb
);

  logic [XW-1:0] om;
  logic [XW-1:0] t;
  logic [XW-1:0] y;

  // 1-x in Q0.32 wraps so that x=0 yields 0.
  assign om = ~x + XW'(1);
  assign y  = XW'((PW'(R_Q) * PW'(t)) >> QR_LO);
  assign wb = floor_x(y, MIN_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
    end else if (en && !phase) begin
      t <= XW'((PW'(x) * PW'(om)) >> XW);
    end
  end

endmodule

// File: rtl/chaos_lmap_gen.sv
// Keyed five-channel logistic-map random source with valid/ready output.
// Ports: clk, rst_n (sync, high), seed_wr/sel/data, start, stop, busy, rand_*.
module chaos_lmap_gen
  import chaos_lmap_gen_pkg::*;
#(
  parameter int          CHAOS_OVLD_W = 32,
  parameter logic [31:0] R_Q          = DEF_R_Q,
  parameter int unsigned WARMUP       = 64,
  parameter logic [31:0] MIN_X        = DEF_MIN_X
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seed_wr,
  input  logic [2:0]              seed_sel,
  input  logic [CHAOS_OVLD_W-1:0] seed_data,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic [CHAOS_OVLD_W-1:0] rand_x1,
  output logic [CHAOS_OVLD_W-1:0] rand_x2,
  output logic [CHAOS_OVLD_W-1:0] rand_x3,
  output logic [CHAOS_OVLD_W-1:0] rand_z1,
  output logic [CHAOS_OVLD_W-1:0] rand_z2,
  output logic                    rand_vld,
  input  logic                    rand_rdy
);

  localparam int CW = $clog2(WARMUP + 1) + 1;

  state_e        state_q;
  state_e        state_d;
  logic [2:0]    ch_q;
  logic          ph_q;
  logic [CW-1:0] cnt_q;
  logic          stop_q;
  logic          vld_q;
  logic [XW-1:0] x_q   [NCH];
  logic [XW-1:0] x_d   [NCH];
  logic [XW-1:0] res_q [NCH];
  logic [XW-1:0] out_q [NCH];
  logic [XW-1:0] wb;
  logic          calc;
  logic          last;
  logic          hs;
  logic          warm;
  logic          done;
  logic          flush;
  logic          load;

  assign calc = state_q == ST_CALC;
  assign last = calc && ph_q && (ch_q == LAST_CH);
  assign hs   = vld_q && rand_rdy;

  lmap_step #(
    .R_Q   (R_Q),
    .MIN_X (MIN_X)
  ) u_step (
    .clk   (clk),
    .rst   (rst_n),
    .en    (calc),
    .phase (ph_q),
    .x     (x_q[ch_q]),
    .wb    (wb)
  );

  always_comb begin
    state_d = state_q;
    warm    = 1'b0;
    done    = 1'b0;
    flush   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (last) begin
          if (stop_q) begin
            flush   = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q != CW'(WARMUP)) begin
            warm = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        if (!vld_q || hs) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Seeds land only in IDLE; the datapath writes back at phase B.
  always_comb begin
    x_d = x_q;
    if (state_q == ST_IDLE && seed_wr && seed_sel <= LAST_CH)
      x_d[seed_sel] = seed_data;
    if (calc && ph_q)
      x_d[ch_q] = wb;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      vld_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        x_q[i]   <= '0;
        res_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      if (calc) begin
        ph_q <= ~ph_q;
        if (ph_q) ch_q <= last ? '0 : ch_q + 3'd1;
      end
      if (state_q == ST_IDLE) begin
        stop_q <= 1'b0;
        if (start) cnt_q <= '0;
      end else if (stop) begin
        stop_q <= 1'b1;
      end
      if (warm) cnt_q <= cnt_q + CW'(1);
      if (done) res_q <= x_d;
      if (flush) begin
        vld_q <= 1'b0;
        for (int i = 0; i < NCH; i++) out_q[i] <= '0;
      end else if (load) begin
        vld_q <= 1'b1;
        out_q <= res_q;
      end else if (hs) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign busy     = state_q != ST_IDLE;
  assign rand_vld = vld_q;
  assign rand_x1  = out_q[0];
  assign rand_x2  = out_q[1];
  assign rand_x3  = out_q[2];
  assign rand_z1  = out_q[3];
  assign rand_z2  = out_q[4];

endmodule

// File: tb/tb_chaos_lmap_gen.sv
// Bench for chaos_lmap_gen: WARMUP=0 and WARMUP=2 instances vs a formula model.
// Directed sequence with random reseeds; immediate assertions at each check.
module tb_chaos_lmap_gen;

  localparam logic [31:0] R    = 32'hFD70_A3D7;
  localparam logic [31:0] MINX = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst2, seed_wr, start, stop, rdy;
  logic [2:0]  seed_sel;
  logic [31:0] seed_data;
  logic        busy0, vld0, busy2, vld2;
  logic [31:0] a_x1, a_x2, a_x3, a_z1, a_z2;
  logic [31:0] b_x1, b_x2, b_x3, b_z1, b_z2;

  chaos_lmap_gen #(.WARMUP(0)) dut0 (
    .clk(clk), .rst_n(rst0), .seed_wr(seed_wr), .seed_sel(seed_sel),
    .seed_data(seed_data), .start(start), .stop(stop), .busy(busy0),
    .rand_x1(a_x1), .rand_x2(a_x2), .rand_x3(a_x3),
    .rand_z1(a_z1), .rand_z2(a_z2), .rand_vld(vld0), .rand_rdy(rdy)
  );

  chaos_lmap_gen #(.WARMUP(2)) dut2 (
    .clk(clk), .rst_n(rst2), .seed_wr(seed_wr), .seed_sel(seed_sel),
    .seed_data(seed_data), .start(start), .stop(stop), .busy(busy2),
    .rand_x1(b_x1), .rand_x2(b_x2), .rand_x3(b_x3),
    .rand_z1(b_z1), .rand_z2(b_z2), .rand_vld(vld2), .rand_rdy(rdy)
  );

  int sel = 0;
  int nrun = 0;
  int nfail = 0;

  logic [159:0] so0, so2, o_set;
  logic         o_vld, o_busy;
  assign so0    = {a_x1, a_x2, a_x3, a_z1, a_z2};
  assign so2    = {b_x1, b_x2, b_x3, b_z1, b_z2};
  assign o_set  = (sel != 0) ? so2 : so0;
  assign o_vld  = (sel != 0) ? vld2 : vld0;
  assign o_busy = (sel != 0) ? busy2 : busy0;

  // Reference orbit: x' = floor(r * x * (1 - x)) with the degeneracy floor.
  logic [31:0] mx [5];

  function automatic logic [31:0] f(input logic [31:0] x);
    longint unsigned p, t, y;
    p = longint'(x) * (64'h1_0000_0000 - longint'(x));
    t = p >> 32;
    y = ((longint'(R) * t) >> 30) & 64'hFFFF_FFFF;
    if (y < longint'(MINX)) y = y | longint'(MINX);
    return y[31:0];
  endfunction

  task automatic adv();
    for (int i = 0; i < 5; i++) mx[i] = f(mx[i]);
  endtask

  function automatic logic [159:0] mset();
    return {mx[0], mx[1], mx[2], mx[3], mx[4]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start   = 1'b0;
    stop    = 1'b0;
    seed_wr = 1'b0;
  endtask

  task automatic wseed(input logic [2:0] s, input logic [31:0] d);
    seed_sel  = s;
    seed_data = d;
    seed_wr   = 1'b1;
    tick();
  endtask

  task automatic expect_set(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_vld && n < 400);
    chk({tag, " vld"}, 160'(o_vld), 160'(1));
    if (lat > 0) chk({tag, " lat"}, 160'(n), 160'(lat));
    adv();
    chk({tag, " set"}, o_set, mset());
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_busy && n < 40);
    chk({tag, " busy"}, 160'(o_busy), 160'(0));
    chk({tag, " vld"}, 160'(o_vld), 160'(0));
    chk({tag, " out"}, o_set, 160'(0));
  endtask

  logic [159:0] saved;
  logic [31:0]  s;

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; rdy = 1'b1;
    start = 1'b0; stop = 1'b0; seed_wr = 1'b0;
    seed_sel = '0; seed_data = '0;
    repeat (3) tick();
    chk("rst vld", 160'(vld0), 160'(0));
    chk("rst busy", 160'(busy0), 160'(0));
    chk("rst out", so0, 160'(0));
    chk("rst busy2", 160'(busy2), 160'(0));
    rst0 = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      wseed(3'(i), HALF);
      mx[i] = HALF;
    end
    start = 1'b1;
    expect_set("basic1", 12);
    chk("basic1 const", o_set, {5{R}});
    expect_set("basic2", 11);

    expect_set("bp3", 11);
    rdy   = 1'b0;
    saved = o_set;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("bp hold vld", 160'(o_vld), 160'(1));
      chk("bp hold set", o_set, saved);
    end
    chk("bp busy", 160'(o_busy), 160'(1));
    rdy = 1'b1;
    tick();
    chk("bp b2b vld", 160'(o_vld), 160'(1));
    adv();
    chk("bp b2b set", o_set, mset());

    stop = 1'b1;
    wait_idle("stop1");
    adv();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle vld", 160'(o_vld), 160'(0));
    end
    start = 1'b1;
    expect_set("resume", 12);
    wseed(3'd0, 32'h1234_5678);
    expect_set("ign seed", 10);
    stop = 1'b1;
    wait_idle("stop2");
    adv();

    wseed(3'd0, 32'h0);
    for (int i = 1; i < 5; i++) wseed(3'(i), HALF);
    wseed(3'd5, 32'hDEAD_BEEF);
    wseed(3'd7, 32'h0BAD_F00D);
    mx[0] = 32'h0;
    for (int i = 1; i < 5; i++) mx[i] = HALF;
    start = 1'b1;
    expect_set("degen", 12);
    chk("degen x1", 160'(a_x1), 160'(MINX));
    chk("degen z2", 160'(a_z2), 160'(R));
    stop = 1'b1;
    wait_idle("stop3");
    adv();

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        s = $urandom;
        wseed(3'(i), s);
        mx[i] = s;
      end
      start = 1'b1;
      expect_set("rnd a", 12);
      expect_set("rnd b", 11);
      expect_set("rnd c", 11);
      stop = 1'b1;
      wait_idle("rnd stop");
      adv();
    end

    start = 1'b1;
    repeat (4) tick();
    chk("mid busy", 160'(busy0), 160'(1));
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("mid rst vld", 160'(vld0), 160'(0));
    chk("mid rst busy", 160'(busy0), 160'(0));
    chk("mid rst out", so0, 160'(0));
    for (int i = 0; i < 5; i++) mx[i] = 32'h0;
    start = 1'b1;
    expect_set("post rst", 12);
    chk("post rst const", o_set, {5{MINX}});

    rst0 = 1'b1;
    rst2 = 1'b0;
    sel  = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wseed(3'(i), HALF);
      mx[i] = HALF;
    end
    start = 1'b1;
    adv();
    adv();
    expect_set("warm", 32);
    expect_set("warm2", 11);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
